// File: rtl/io_poll_seq.sv
// rtl/io_poll_seq.sv - CPU access and auto-poll sequencer for a 4-register peripheral
// Optional auto-poll engine compiled in with IO_POLL_SEQ_AUTOPOLL_EN.
module io_poll_seq #(
  parameter int POLL_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        poll_en,
  output logic        sw_valid,
  output logic [15:0] sw_value,
  output logic        p_read,
  output logic        p_write,
  output logic [1:0]  p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata
);

  typedef enum logic [3:0] {
    IDLE,
    CPU_RD,
    CPU_RD_WAIT,
    CPU_WR,
    POLL_ST,
    POLL_ST_WAIT,
    POLL_LO,
    POLL_LO_WAIT,
    POLL_HI,
    POLL_HI_WAIT
  } state_t;

  // Timer value at which a poll becomes pending.
  localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

  // Peripheral register map used by the poll sequence.
  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_SW_LO  = 2'b10;
  localparam logic [1:0] ADDR_SW_HI  = 2'b11;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        accept;
  logic        poll_launch;

  // The read/write decision is carried by the state itself (CPU_RD vs CPU_WR).
  assign accept = (state == IDLE) && cmd_valid;

`ifdef IO_POLL_SEQ_AUTOPOLL_EN
  logic [15:0] poll_timer;
  logic        poll_pending;
  logic [7:0]  lo_byte;
  logic        sw_valid_q;
  logic [15:0] sw_value_q;

  // A CPU request in the same IDLE cycle takes priority; the poll stays pending.
  assign poll_pending = poll_en && (poll_timer == POLL_LAST);
  assign poll_launch  = (state == IDLE) && !cmd_valid && poll_pending;

  // Poll timer: counts while enabled, saturates at POLL_LAST, cleared on launch or disable.
  always_ff @(posedge clk) begin
    if (reset || !poll_en || poll_launch) begin
      poll_timer <= '0;
    end else if (poll_timer != POLL_LAST) begin
      poll_timer <= poll_timer + 16'd1;
    end
  end

  // Switch capture: low byte held until the high byte arrives, then published.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_byte    <= '0;
      sw_valid_q <= 1'b0;
      sw_value_q <= '0;
    end else begin
      sw_valid_q <= (state == POLL_HI_WAIT);
      if (state == POLL_LO_WAIT) begin
        lo_byte <= p_rdata[7:0];
      end
      if (state == POLL_HI_WAIT) begin
        sw_value_q <= {p_rdata[7:0], lo_byte};
      end
    end
  end

  assign sw_valid = sw_valid_q;
  assign sw_value = sw_value_q;
`else
  logic        unused_poll_en;
  logic [15:0] unused_poll_last;

  assign unused_poll_en   = poll_en;
  assign unused_poll_last = POLL_LAST;
  assign poll_launch      = 1'b0;
  assign sw_valid         = 1'b0;
  assign sw_value         = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; poll sequence runs to completion regardless of poll_en.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = cmd_write ? CPU_WR : CPU_RD;
        end else if (poll_launch) begin
          state_nx = POLL_ST;
        end
      end
      CPU_RD:       state_nx = CPU_RD_WAIT;
      CPU_RD_WAIT:  state_nx = IDLE;
      CPU_WR:       state_nx = IDLE;
      POLL_ST:      state_nx = POLL_ST_WAIT;
      POLL_ST_WAIT: state_nx = p_rdata[1] ? POLL_LO : IDLE;
      POLL_LO:      state_nx = POLL_LO_WAIT;
      POLL_LO_WAIT: state_nx = POLL_HI;
      POLL_HI:      state_nx = POLL_HI_WAIT;
      POLL_HI_WAIT: state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  // Output decode: strobes, address and write data come purely from state.
  always_comb begin
    cmd_ready = 1'b0;
    p_read    = 1'b0;
    p_write   = 1'b0;
    p_addr    = '0;
    p_wdata   = '0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      CPU_RD: begin
        p_read = 1'b1;
        p_addr = req_addr;
      end
      CPU_WR: begin
        p_write = 1'b1;
        p_addr  = req_addr;
        p_wdata = req_wdata;
      end
      POLL_ST: begin
        p_read = 1'b1;
        p_addr = ADDR_STATUS;
      end
      POLL_LO: begin
        p_read = 1'b1;
        p_addr = ADDR_SW_LO;
      end
      POLL_HI: begin
        p_read = 1'b1;
        p_addr = ADDR_SW_HI;
      end
      default: ;
    endcase
  end

  // Request latch: address and write data captured on the accepting cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (accept) begin
      req_addr  <= cmd_addr;
      req_wdata <= cmd_wdata;
    end
  end

  // CPU response: pulse after the read wait or the write strobe; data held between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == CPU_RD_WAIT) || (state == CPU_WR);
      if (state == CPU_RD_WAIT) begin
        rsp_rdata <= p_rdata;
      end else if (state == CPU_WR) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/io_poll_seq.md
IO_POLL_SEQ -- requirements
Module: io_poll_seq

Interface
REQ-001 Parameter POLL_PERIOD, default 1000: cycles between auto-poll launches; legal range 4..65535.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cmd_valid  in  1  CPU access request.
REQ-005 cmd_ready  out  1  controller accepts a request; high only in IDLE.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  2  peripheral register address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle pulse: CPU access complete.
REQ-010 rsp_rdata  out  32  read data, held until the next rsp_valid; 0 for writes.
REQ-011 poll_en  in  1  enables the auto-poll engine.
REQ-012 sw_valid  out  1  one-cycle pulse: new switch value captured.
REQ-013 sw_value  out  16  last polled switch value, held.
REQ-014 p_read, p_write  out  1 each  peripheral strobes; never both high.
REQ-015 p_addr  out  2; p_wdata  out  32  peripheral address and write data.
REQ-016 p_rdata  in  32  peripheral read data, registered by the peripheral: valid the cycle after p_read.

Function
REQ-017 FSM states SHALL be IDLE, CPU_RD, CPU_RD_WAIT, CPU_WR, POLL_ST, POLL_ST_WAIT, POLL_LO, POLL_LO_WAIT, POLL_HI, POLL_HI_WAIT.
REQ-018 Strobes SHALL decode from state: p_read in CPU_RD/POLL_ST/POLL_LO/POLL_HI, p_write in CPU_WR, otherwise 0; p_addr/p_wdata = 0 when no strobe.
REQ-019 Handshake: request accepted in cycle N when cmd_valid & cmd_ready; addr/wdata/write latched in N.
REQ-020 Read: p_read with p_addr = latched addr in N+1; p_rdata captured in N+2; rsp_valid high in N+3 with rsp_rdata = captured value.
REQ-021 Write: p_write with p_addr/p_wdata in N+1; rsp_valid in N+2, rsp_rdata = 0.
REQ-022 Poll timer: 16-bit counter, increments in every cycle while poll_en = 1, saturates at POLL_PERIOD-1 (poll pending); cleared to 0 when a poll sequence launches or poll_en = 0.
REQ-023 Poll sequence, atomic: POLL_ST reads addr 2'b00; if captured bit1 = 0, return to IDLE without pulse; else POLL_LO reads 2'b10, POLL_HI reads 2'b11; sw_value = {hi[7:0], lo[7:0]}, sw_valid pulses in the cycle after POLL_HI_WAIT.
REQ-024 Arbitration in IDLE: CPU request wins over a pending poll; the pending poll launches on the first IDLE cycle with no cmd_valid.
REQ-025 cmd_ready SHALL be 0 in every non-IDLE state; back-to-back CPU accesses therefore cost 3 (read) or 2 (write) cycles minimum.
REQ-026 Deassertion of poll_en mid-sequence SHALL NOT abort the sequence; it only clears the timer.

Reset
REQ-027 Reset SHALL force IDLE and clear timer, latched request, rsp_valid, rsp_rdata, sw_valid, sw_value to 0; all p_* outputs 0 in the following cycle.
REQ-028 Reset mid-access SHALL drop the access with no rsp_valid; the CPU re-issues.

Configuration
REQ-029 Macro IO_POLL_SEQ_AUTOPOLL_EN: when defined, the auto-poll engine (timer, POLL_* states, sw_value/sw_valid) is compiled in.
REQ-030 Without IO_POLL_SEQ_AUTOPOLL_EN, poll_en is ignored, no POLL_* state is reachable, sw_valid and sw_value are tied to 0; CPU path unchanged.

Verification
REQ-031 CPU read addr 2'b10, peripheral returns 32'h0000_005A -> p_read in N+1, rsp_valid in N+3, rsp_rdata = 32'h5A.
REQ-032 CPU write addr 2'b01 data 32'h0000_0ABC -> p_write, p_addr = 1, p_wdata = 32'hABC in N+1; rsp_valid in N+2, rsp_rdata = 0.
REQ-033 POLL_PERIOD = 8, poll_en = 1, status = 2'b10, switches 16'hBEEF -> reads at addr 0, 2, 3 in sequence; sw_valid once, sw_value = 16'hBEEF.
REQ-034 Poll pending and cmd_valid in the same IDLE cycle -> CPU access completes first, poll launches the next idle cycle; status = 2'b00 -> single read, no sw_valid.
REQ-035 Reset asserted in CPU_RD_WAIT -> no rsp_valid, all outputs 0, cmd_ready = 1 the cycle after reset release.
REQ-036 Build without IO_POLL_SEQ_AUTOPOLL_EN, poll_en = 1 for 100 cycles -> no p_read issued, sw_valid never high.
